coin_acc: RTL
=============

COIN_ACC -- requirements
Module: coin_acc

Interface
REQ-001 Parameter PRICE, default 15, vend price in credit units; SHALL be a multiple of 5 in the range 5..30.
REQ-002 Parameter HOLD, default 2, dead cycles after the select pulse, covering downstream sequencing; range 1..7.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rset  in  1  reset; asynchronous, active-high.
REQ-005 coin  in  2  one-cycle coin pulse: 01 = 5 units, 10 = 10 units, 11 = invalid, 00 = none.
REQ-006 sel  in  1  one-cycle product-select pulse.
REQ-007 cancel  in  1  one-cycle refund request.
REQ-008 slif  out  2  to the downstream sale sequencer: [0] is the paid pulse, [1] is the select pulse; both are registered and one cycle wide.
REQ-009 chg  out  1  registered change pulse; one pulse returns 5 units.
REQ-010 rej  out  1  registered coin-reject pulse.
REQ-011 credit  out  5  current credit, unsigned.
REQ-012 busy  out  1  high in VEND and CHANGE.

Function
REQ-013 The state machine SHALL have five states: IDLE (credit = 0), COLLECT (0 < credit < PRICE), READY (credit >= PRICE), VEND and CHANGE.
REQ-014 All outputs SHALL be registered; an input sampled at edge N SHALL give its response after edge N.
REQ-015 slif, chg and rej SHALL each be high for exactly one cycle per event and low otherwise.
REQ-016 In IDLE or COLLECT, a valid coin SHALL add 5 or 10 to credit, provided the sum is <= 31.
REQ-017 A coin of 11, or a coin that would push credit above 31, SHALL leave credit unchanged and pulse rej.
REQ-018 In IDLE or COLLECT, when credit after an accepted coin is >= PRICE:
- the state SHALL go to READY;
- slif[0] SHALL pulse in the same update.
REQ-019 slif[0] SHALL pulse at most once per transaction.
REQ-020 In IDLE or COLLECT, an accepted coin that leaves credit < PRICE SHALL move IDLE to COLLECT, or keep the state at COLLECT.
REQ-021 In READY, every coin, including 11, SHALL be rejected with a rej pulse.
REQ-022 In READY, sel SHALL do all of the following in one update:
- pulse slif[1];
- subtract PRICE from credit;
- load the hold counter with HOLD;
- enter VEND.
REQ-023 sel SHALL be ignored in IDLE, COLLECT, VEND and CHANGE.
REQ-024 VEND SHALL decrement the hold counter each cycle; when the counter reaches 0, the state SHALL go to CHANGE if credit > 0, else to IDLE.
REQ-025 CHANGE SHALL pulse chg and subtract 5 from credit each cycle; the state SHALL go to IDLE on the update that makes credit 0.
REQ-026 In COLLECT, cancel SHALL enter CHANGE and refund all credit; slif SHALL stay 0.
REQ-027 cancel SHALL have priority over a coin in the same cycle; that coin SHALL be rejected.
REQ-028 cancel SHALL be ignored in IDLE, READY, VEND and CHANGE.
REQ-029 Coins arriving in VEND or CHANGE SHALL be rejected.
REQ-030 Credit SHALL always be a multiple of 5; credit SHALL never wrap and never go negative.

Reset
REQ-031 While rset is high:
- state SHALL be IDLE;
- credit SHALL be 0;
- the hold counter SHALL be 0;
- slif, chg, rej and busy SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL discard credit with no chg pulses.
REQ-033 After rset falls, the first edge SHALL process inputs normally.

Verification
REQ-034 Paid-and-selected with change (PRICE 15): coin 10 at edge 1, coin 10 at edge 3 → credit 10, then 20; slif[0] one cycle after edge 3. sel → slif[1], credit 5; after 2 VEND cycles, one chg pulse; credit 0; IDLE.
REQ-035 Exact pay: coin 5, 5, 5 → slif[0] after the third coin. sel → slif[1]; VEND 2 cycles; back to IDLE with no chg; busy high for exactly 2 cycles.
REQ-036 Cancel: coin 10, then cancel together with coin 5 → rej pulse; 2 chg pulses on consecutive cycles; credit 0; slif stays 00.
REQ-037 Rejects: coin 11 in IDLE → rej, credit 0. Coin 5 while READY (credit 20) → rej, credit 20. cancel in READY → no effect.
REQ-038 Reset mid-CHANGE: credit 10 in CHANGE, assert rset → credit 0, chg 0 immediately (asynchronous), state IDLE. Release rset, then coin 5 → credit 5.

Source files
------------

// File: rtl/coin_acc.sv
// Coin acceptor / vend controller: collects 5- and 10-unit coins, signals payment,
// hands off to the sale sequencer on select, then pays out change one 5-unit pulse at a time.
module coin_acc #(
  parameter int unsigned PRICE = 15,
  parameter int unsigned HOLD  = 2
) (
  input  logic       clk,
  input  logic       rset,
  input  logic [1:0] coin,
  input  logic       sel,
  input  logic       cancel,
  output logic [1:0] slif,
  output logic       chg,
  output logic       rej,
  output logic [4:0] credit,
  output logic       busy
);

  typedef enum logic [2:0] {StIdle, StCollect, StReady, StVend, StChange} state_e;

  localparam logic [4:0] Price  = 5'(PRICE);
  localparam logic [5:0] PriceW = 6'(PRICE);
  localparam logic [2:0] Hold   = 3'(HOLD);

  state_e     state;
  logic [2:0] hold;
  logic [4:0] coin_val;
  logic [5:0] coin_sum;
  logic       coin_ok;

  // Six-bit sum so a coin that would overflow the 5-bit credit is caught, not wrapped.
  always_comb begin
    coin_val = 5'd0;
    unique case (coin)
      2'b01:   coin_val = 5'd5;
      2'b10:   coin_val = 5'd10;
      default: coin_val = 5'd0;
    endcase
    coin_sum = {1'b0, credit} + {1'b0, coin_val};
    coin_ok  = (coin_val != 5'd0) && (coin_sum <= 6'd31);
  end

  always_ff @(posedge clk or posedge rset) begin
    if (rset) begin
      state  <= StIdle;
      hold   <= 3'd0;
      credit <= 5'd0;
      slif   <= 2'b00;
      chg    <= 1'b0;
      rej    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      slif <= 2'b00;
      chg  <= 1'b0;
      rej  <= 1'b0;
      case (state)
        StIdle, StCollect: begin
          if (cancel && (state == StCollect)) begin
            // Refund wins over a coin in the same cycle; that coin bounces.
            state <= StChange;
            busy  <= 1'b1;
            rej   <= (coin != 2'b00);
          end else if (coin != 2'b00) begin
            if (coin_ok) begin
              credit <= coin_sum[4:0];
              if (coin_sum >= PriceW) begin
                state   <= StReady;
                slif[0] <= 1'b1;
              end else begin
                state <= StCollect;
              end
            end else begin
              rej <= 1'b1;
            end
          end
        end
        StReady: begin
          rej <= (coin != 2'b00);
          if (sel) begin
            slif[1] <= 1'b1;
            credit  <= credit - Price;
            hold    <= Hold;
            state   <= StVend;
            busy    <= 1'b1;
          end
        end
        StVend: begin
          rej  <= (coin != 2'b00);
          hold <= hold - 3'd1;
          if (hold <= 3'd1) begin
            if (credit != 5'd0) begin
              state <= StChange;
            end else begin
              state <= StIdle;
              busy  <= 1'b0;
            end
          end
        end
        StChange: begin
          rej    <= (coin != 2'b00);
          chg    <= 1'b1;
          credit <= credit - 5'd5;
          if (credit <= 5'd5) begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
